// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/result handshake bundle for seq_shift_add_multiplier.
// master drives operands and out_ready; slave is the multiplier.
interface seq_shift_add_multiplier_if #(
  parameter int QW = 8,
  parameter int YW = 9,
  parameter int RW = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [QW-1:0]     a_in;
  logic [YW-1:0]     b_in;
  logic [RW-1:0]     c_in;
  logic              out_valid;
  logic              out_ready;
  logic [QW+YW-1:0]  prod;
  logic [YW-1:0]     prod_hi;
  logic              busy;

  modport master (
    output in_valid, a_in, b_in, c_in, out_ready,
    input  in_ready, out_valid, prod, prod_hi, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, c_in, out_ready,
    output in_ready, out_valid, prod, prod_hi, busy
  );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier: P = A*B + C, one multiplier bit per clock.
// Define MUL_ROUND_EN to make prod_hi round-half-up instead of truncating.
module seq_shift_add_multiplier #(
  parameter int QW = 8,
  parameter int YW = 9,
  parameter int RW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_shift_add_multiplier_if.slave bus
);
  localparam int PW = QW + YW;
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [QW-1:0]   a_sh;
  logic [YW-1:0]   b_reg;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   count;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic            busy_reg;
  logic [PW-1:0]   prod_reg;
  logic [YW-1:0]   prod_hi_reg;

  logic [PW-1:0]   addend;
  logic [PW-1:0]   acc_next;
  logic [YW-1:0]   hi_next;

  always_comb begin
    addend   = a_sh[0] ? ({{QW{1'b0}}, b_reg} << count) : '0;
    acc_next = acc + addend;
`ifdef MUL_ROUND_EN
    // (P + 2^(QW-1)) >> QW equals the truncated part plus the bit just below it
    hi_next  = acc_next[PW-1:QW] + YW'(acc_next[QW-1]);
`else
    hi_next  = acc_next[PW-1:QW];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_sh          <= '0;
      b_reg         <= '0;
      acc           <= '0;
      count         <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      prod_reg      <= '0;
      prod_hi_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            a_sh         <= bus.a_in;
            b_reg        <= bus.b_in;
            acc          <= PW'(bus.c_in);
            count        <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state        <= BUSY;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          a_sh  <= a_sh >> 1;
          count <= count + 1'b1;
          if (count == CW'(QW - 1)) begin
            prod_reg      <= acc_next;
            prod_hi_reg   <= hi_next;
            out_valid_reg <= 1'b1;
            busy_reg      <= 1'b0;
            count         <= '0;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.prod      = prod_reg;
  assign bus.prod_hi   = prod_hi_reg;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier: arithmetic model plus literal vectors.
// Build with +define+MUL_ROUND_EN to check the rounding variant of prod_hi.
module tb_seq_shift_add_multiplier;
  localparam int QW = 8;
  localparam int YW = 9;
  localparam int RW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_shift_add_multiplier_if #(.QW(QW), .YW(YW), .RW(RW)) bus ();

  seq_shift_add_multiplier #(.QW(QW), .YW(YW), .RW(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  int unsigned exp_q[$];
  int accept_q[$];
  logic prev_valid = 1'b0;

  function automatic int unsigned model_hi(int unsigned p);
`ifdef MUL_ROUND_EN
    return (p + (1 << (QW - 1))) >> QW;
`else
    return p >> QW;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Transaction bookkeeping happens on the active edge, where handshakes complete
  always @(posedge clk) begin
    edge_cnt++;
    if (!rst_n) begin
      exp_q.delete();
      accept_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(accept_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(int'(bus.a_in) * int'(bus.b_in) + int'(bus.c_in));
        accept_q.push_back(edge_cnt);
        $display("accept  A=0x%02h B=0x%03h C=0x%02h at edge %0d", bus.a_in, bus.b_in, bus.c_in, edge_cnt);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      check("busy", {31'd0, bus.busy}, {31'd0, (exp_q.size() > 0 && !bus.out_valid)});
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_without_txn", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          check("model_prod", {15'd0, bus.prod}, exp_q[0]);
          check("model_prod_hi", {23'd0, bus.prod_hi}, model_hi(exp_q[0]));
          check("in_ready_in_done", {31'd0, bus.in_ready}, 32'd0);
          if (!prev_valid) begin
            check("latency", edge_cnt - accept_q[0], QW);
            $display("result  prod=0x%05h prod_hi=0x%03h at edge %0d", bus.prod, bus.prod_hi, edge_cnt);
          end
        end
      end
      prev_valid = bus.out_valid;
    end
  end

  task automatic send(input logic [QW-1:0] a, input logic [YW-1:0] b, input logic [RW-1:0] c);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus.a_in = a;
    bus.b_in = b;
    bus.c_in = c;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("result_timeout", 32'd0, 32'd1);
  endtask

  // out_ready is already high when out_valid rises, so the transfer completes at once
  task automatic run(input logic [QW-1:0] a, input logic [YW-1:0] b, input logic [RW-1:0] c,
                     input logic [31:0] exp_p, input logic [31:0] hi_trunc, input logic [31:0] hi_round);
    bus.out_ready = 1'b1;
    send(a, b, c);
    wait_result();
    check("lit_prod", {15'd0, bus.prod}, exp_p);
`ifdef MUL_ROUND_EN
    check("lit_prod_hi", {23'd0, bus.prod_hi}, hi_round);
`else
    check("lit_prod_hi", {23'd0, bus.prod_hi}, hi_trunc);
`endif
    @(posedge clk);
    #1;
    check("out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    check("in_ready_back", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.c_in      = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_prod", {15'd0, bus.prod}, 32'd0);
    check("rst_prod_hi", {23'd0, bus.prod_hi}, 32'd0);
    rst_n = 1'b1;

    // Reset three edges into BUSY: outputs return to reset values immediately
    bus.out_ready = 1'b1;
    send(8'hFF, 9'h1FF, 8'h00);
    repeat (2) @(posedge clk);
    #2;
    check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_prod", {15'd0, bus.prod}, 32'd0);
    check("midrst_prod_hi", {23'd0, bus.prod_hi}, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    run(8'h03, 9'h005, 8'h00, 32'h0000F, 32'h000, 32'h000);

    run(8'h80, 9'h100, 8'h00, 32'h08000, 32'h080, 32'h080);
    run(8'hFF, 9'h1FF, 8'hFF, 32'h1FE00, 32'h1FE, 32'h1FE);
    run(8'h01, 9'h180, 8'h00, 32'h00180, 32'h001, 32'h002);
    run(8'h00, 9'h1FF, 8'hAB, 32'h000AB, 32'h000, 32'h000);
    run(8'h5A, 9'h000, 8'h3C, 32'h0003C, 32'h000, 32'h000);
    run(8'hC3, 9'h0A5, 8'h00, 32'h07DAF, 32'h07D, 32'h07E);

    // Backpressure with the next operands already waiting on in_valid
    bus.out_ready = 1'b0;
    send(8'h05, 9'h007, 8'h02);
    wait_result();
    check("bp_first_prod", {15'd0, bus.prod}, 32'h00025);
    #1;
    bus.a_in = 8'h02;
    bus.b_in = 9'h003;
    bus.c_in = 8'h01;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_prod_stable", {15'd0, bus.prod}, 32'h00025);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("bp_idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_second_accepted", {31'd0, bus.busy}, 32'd1);
    wait_result();
    check("bp_second_prod", {15'd0, bus.prod}, 32'h00007);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_second_drop", {31'd0, bus.out_valid}, 32'd0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
